// File: rtl/disp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_pkg: shared constants, types and helpers for the display scanner.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package disp_pkg;

  localparam int SEG_MAX_W = 64;
  localparam logic [SEG_MAX_W-1:0] SEG_OFF = '1;

  localparam int IDX_MAX_W = 8;
  typedef logic [IDX_MAX_W-1:0] digit_idx_t;

  // Keep at least one index bit so a 1-digit build still elaborates.
  function automatic int idx_width(input int digits);
    return (digits < 2) ? 1 : $clog2(digits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_slot_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sseg_slot_timer: slot counter and digit index with enable/freeze.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sseg_slot_timer
  import disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_LOG2 = 16,
  localparam int IDX_W    = idx_width(DIGITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [SLOT_LOG2-1:0] slot_cnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 frame_start
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(DIGITS - 1);

  logic [SLOT_LOG2-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    if (en) begin
      slot_d = slot_q + SLOT_LOG2'(1);
      if (&slot_q) begin
        idx_d = (idx_q == LAST_IDX[IDX_W-1:0]) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  assign slot_cnt    = slot_q;
  assign idx         = idx_q;
  assign frame_start = en && (slot_q == '0) && (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sseg_scan_ctrl: multiplexed N-digit scanner with PWM, blanking, shadow.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sseg_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SEG_W     = 8,
  parameter int SLOT_LOG2 = 16,
  parameter int BRIGHT_W  = 4,
  localparam int IDX_W    = idx_width(DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIGITS*SEG_W-1:0] din,
  input  logic [DIGITS-1:0]       blank,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [SEG_W-1:0]        sseg,
  output logic [DIGITS-1:0]       an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  logic [SLOT_LOG2-1:0]    slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    frame_start;

  logic [DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [SEG_W-1:0]        sseg_q, sseg_d;
  logic                    frame_tick_q;

  logic [BRIGHT_W-1:0]     phase;
  logic                    lit;
  logic                    show;
  logic                    unused_slot_bits;

  sseg_slot_timer #(
    .DIGITS    (DIGITS),
    .SLOT_LOG2 (SLOT_LOG2)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .slot_cnt    (slot_cnt),
    .idx         (idx),
    .frame_start (frame_start)
  );

  assign phase            = slot_cnt[SLOT_LOG2-1 -: BRIGHT_W];
  assign unused_slot_bits = ^slot_cnt;
  assign lit              = (&bright) || (phase < bright);
  assign show             = en && lit && !blank[idx];

  // Decode from the next shadow so the capture cycle already shows the new frame.
  assign shadow_d = frame_start ? din : shadow_q;

  always_comb begin
    sseg_d = show ? shadow_d[idx*SEG_W +: SEG_W] : SEG_OFF[SEG_W-1:0];
    an_d   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (show && (idx == IDX_W'(k))) begin
        an_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '1;
      an_q         <= '1;
      sseg_q       <= SEG_OFF[SEG_W-1:0];
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_start;
    end
  end

  assign sseg       = sseg_q;
  assign an         = an_q;
  assign digit_idx  = idx;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sseg_scan_ctrl: directed scenarios with a queue-based scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic [3:0]  blank;
  logic [1:0]  bright;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  sseg_scan_ctrl #(
    .DIGITS    (4),
    .SEG_W     (8),
    .SLOT_LOG2 (4),
    .BRIGHT_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .blank      (blank),
    .bright     (bright),
    .sseg       (sseg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Reference position: pos = 16*digit + slot of the state seen at the next edge.
  int         pos;
  logic [7:0] exp_dig [4];

  task automatic reset_step(input string name);
    exp_t e;
    e.an = 4'hF; e.sseg = 8'hFF; e.ft = 1'b0; e.idx = 2'd0; e.name = name;
    pos = 0;
    for (int i = 0; i < 4; i++) exp_dig[i] = 8'hFF;
    @(posedge clk); #1;
    e.cyc = cyc_cnt;
    q.push_back(e);
  endtask

  task automatic step(input string name);
    exp_t       e;
    logic [1:0] d;
    logic [1:0] ph;
    logic       lit;
    d = 2'(pos / 16);
    e.an = 4'hF; e.sseg = 8'hFF; e.ft = 1'b0; e.name = name;
    if (en) begin
      if (pos == 0) begin
        for (int i = 0; i < 4; i++) exp_dig[i] = din[i*8 +: 8];
      end
      ph  = 2'((pos % 16) / 4);
      lit = (bright == 2'b11) || (ph < bright);
      if (lit && !blank[d]) begin
        e.an   = ~(4'b0001 << d);
        e.sseg = exp_dig[d];
      end
      e.ft = (pos == 0);
      pos  = (pos + 1) % 64;
    end
    e.idx = 2'(pos / 16);
    @(posedge clk); #1;
    e.cyc = cyc_cnt;
    q.push_back(e);
  endtask

  task automatic run_to(input int target, input string name);
    int guard = 0;
    while (pos != target && guard < 200) begin
      step(name);
      guard++;
    end
  endtask

  // Monitor: compare every expectation due this cycle against the DUT outputs.
  initial begin : monitor
    exp_t        e;
    logic [14:0] act, req;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        total_cnt++;
        act = {an, sseg, frame_tick, digit_idx};
        req = {e.an, e.sseg, e.ft, e.idx};
        if (e.cyc != cyc_cnt)
          $display("FAIL %s: stale expectation from cycle %0d at cycle %0d", e.name, e.cyc, cyc_cnt);
        else if (act === req)
          pass_cnt++;
        else
          $display("FAIL %s @%0d: got an=%h sseg=%h ft=%b idx=%0d, expected an=%h sseg=%h ft=%b idx=%0d",
                   e.name, cyc_cnt, an, sseg, frame_tick, digit_idx, e.an, e.sseg, e.ft, e.idx);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b1; blank = 4'b0000; bright = 2'd3;
    din = {8'h03, 8'h02, 8'h01, 8'h00};
    reset_step("reset");
    reset_step("reset");
    rst = 1'b0;

    // Basic scan: a full frame plus the next frame start.
    repeat (65) step("scan");

    // Brightness: quarter duty, then off.
    bright = 2'd1;
    run_to(0, "bright1");
    repeat (64) step("bright1");
    bright = 2'd0;
    repeat (64) step("bright0");

    // Blanking of digit 2.
    bright = 2'd3; blank = 4'b0100;
    repeat (64) step("blank");
    blank = 4'b0000;

    // Coherence: mid-frame din edits wait for the next frame start.
    run_to(20, "coher");
    din[7:0]   = 8'h55;
    din[31:24] = 8'hAA;
    run_to(10, "coher");

    // Enable hold at slot 5 of digit 1.
    run_to(21, "pre_hold");
    en = 1'b0;
    repeat (10) step("hold");
    en = 1'b1;
    repeat (11) step("resume");
    run_to(1, "after_hold");

    // Reset mid-frame at digit 2, then restart with fresh data.
    run_to(37, "pre_rst");
    rst = 1'b1;
    reset_step("rst_mid");
    rst = 1'b0;
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (70) step("restart");

    // Reset while disabled, idle, then resume.
    en = 1'b0; rst = 1'b1;
    reset_step("rst_en0");
    rst = 1'b0;
    repeat (3) step("idle");
    en = 1'b1;
    repeat (20) step("resume2");

    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
